// File: rtl/lte_sym_framer.sv
// LTE receive symbol framer: turns a slot-strobed sample stream into per-symbol
// head/slot flags for the FFT, flywheeling over missing slot heads and resyncing on misplaced ones.
`timescale 1ns/1ps
module lte_sym_framer #(
  parameter int BIT_WIDTH    = 16,
  parameter int CLK_FS_RATIO = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [1:0]           FFT_num,
  input  logic                 CP_type,
  input  logic [BIT_WIDTH-1:0] In_i,
  input  logic [BIT_WIDTH-1:0] In_q,
  input  logic                 In_v,
  input  logic                 In_s,
  output logic [BIT_WIDTH-1:0] Dout_i,
  output logic [BIT_WIDTH-1:0] Dout_q,
  output logic                 Dout_h,
  output logic                 Dout_s,
  output logic                 Dout_v,
  output logic [2:0]           Sym_idx,
  output logic                 Sync_err
);

  if (CLK_FS_RATIO < 1) begin : g_bad_ratio
    $error("CLK_FS_RATIO must be at least 1");
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [1:0]  cfg_fft, use_fft;
  logic        cfg_ext, use_ext;
  logic [11:0] cnt, cur_cnt, nxt_cnt, len_m1;
  logic [2:0]  sym, cur_sym, nxt_sym, last_sym;
  logic        take, resync, err;

  // Symbol length minus one (CP + N - 1) from a constant table.
  function automatic logic [11:0] sym_len_m1(input logic [1:0] fft, input logic ext,
                                             input logic [2:0] s);
    logic [11:0] n, cp;
    case (fft)
      2'd0:    begin n = 12'd2048; cp = (s == 3'd0) ? 12'd160 : 12'd144; end
      2'd1:    begin n = 12'd1536; cp = (s == 3'd0) ? 12'd120 : 12'd108; end
      2'd2:    begin n = 12'd1024; cp = (s == 3'd0) ? 12'd80  : 12'd72;  end
      default: begin n = 12'd512;  cp = (s == 3'd0) ? 12'd40  : 12'd36;  end
    endcase
    if (ext) cp = n >> 2;
    return n + cp - 12'd1;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    resync    = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: if (In_v && In_s) begin
        state_nxt = RUN;
        take      = 1'b1;
        resync    = 1'b1;
      end
      RUN: if (In_v) begin
        take   = 1'b1;
        resync = In_s;
        // Counters at (0,0) mark the slot boundary: a head elsewhere is misplaced,
        // no head here is missing.
        err    = In_s ^ (sym == 3'd0 && cnt == 12'd0);
      end
      default: state_nxt = IDLE;
    endcase
    use_fft = resync ? FFT_num : cfg_fft;
    use_ext = resync ? CP_type : cfg_ext;
    cur_sym = resync ? 3'd0  : sym;
    cur_cnt = resync ? 12'd0 : cnt;
    len_m1   = sym_len_m1(use_fft, use_ext, cur_sym);
    last_sym = use_ext ? 3'd5 : 3'd6;
    nxt_cnt  = cur_cnt + 12'd1;
    nxt_sym  = cur_sym;
    if (cur_cnt == len_m1) begin
      nxt_cnt = 12'd0;
      nxt_sym = (cur_sym == last_sym) ? 3'd0 : cur_sym + 3'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      cfg_fft  <= 2'd0;
      cfg_ext  <= 1'b0;
      cnt      <= '0;
      sym      <= '0;
      Dout_i   <= '0;
      Dout_q   <= '0;
      Dout_h   <= 1'b0;
      Dout_s   <= 1'b0;
      Dout_v   <= 1'b0;
      Sym_idx  <= '0;
      Sync_err <= 1'b0;
    end else begin
      Dout_v   <= take;
      Dout_h   <= take && cur_cnt == 12'd0;
      Dout_s   <= take && cur_cnt == 12'd0 && cur_sym == 3'd0;
      Sync_err <= err;
      if (take) begin
        cnt     <= nxt_cnt;
        sym     <= nxt_sym;
        Dout_i  <= In_i;
        Dout_q  <= In_q;
        Sym_idx <= cur_sym;
      end
      if (resync) begin
        cfg_fft <= FFT_num;
        cfg_ext <= CP_type;
      end
    end

endmodule
